// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one dual-port masked SRAM macro (one read port, one write port) among
// NUM_REQ requesters. The read port and the write port are arbitrated
// independently, each with its own round-robin pointer. Read data comes back
// from the macro one cycle after REB and is steered to the requester that won
// the read, tagged by a one-hot rsp_valid.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   rd_valid / rd_ready  per-requester read request / grant (combinational)
//   rd_addr              packed read addresses, requester i at [i*AW +: AW]
//   rsp_valid / rsp_data one-hot read response strobe / read data (Q passthrough)
//   wr_valid / wr_ready  per-requester write request / grant (combinational)
//   wr_addr              packed write addresses, same packing as rd_addr
//   wr_data / wr_mask    packed write data / bit mask (1 = overwrite)
//   REB, AB              macro read enable / read address
//   WEB, AA, D, M        macro write enable / address / data / mask
//   Q                    macro registered read data
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
    parameter int WIDTH    = 128,
    parameter int NUM_ROWS = 4096,
    parameter int NUM_REQ  = 2,
    localparam int ADDRESS_WIDTH = $clog2(NUM_ROWS)
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [NUM_REQ-1:0]               rd_valid,
    output logic [NUM_REQ-1:0]               rd_ready,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [WIDTH-1:0]                 rsp_data,
    input  logic [NUM_REQ-1:0]               wr_valid,
    output logic [NUM_REQ-1:0]               wr_ready,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [NUM_REQ*WIDTH-1:0]         wr_data,
    input  logic [NUM_REQ*WIDTH-1:0]         wr_mask,
    output logic                             REB,
    output logic [ADDRESS_WIDTH-1:0]         AB,
    output logic                             WEB,
    output logic [ADDRESS_WIDTH-1:0]         AA,
    output logic [WIDTH-1:0]                 D,
    output logic [WIDTH-1:0]                 M,
    input  logic [WIDTH-1:0]                 Q
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW:0]   NREQ = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    // Unpacked views of the packed requester buses.
    logic [ADDRESS_WIDTH-1:0] rd_addr_arr [NUM_REQ];
    logic [ADDRESS_WIDTH-1:0] wr_addr_arr [NUM_REQ];
    logic [WIDTH-1:0]         wr_data_arr [NUM_REQ];
    logic [WIDTH-1:0]         wr_mask_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign rd_addr_arr[gi] = rd_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign wr_addr_arr[gi] = wr_addr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign wr_data_arr[gi] = wr_data[gi*WIDTH +: WIDTH];
            assign wr_mask_arr[gi] = wr_mask[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin pick: returns {found, index}. The loop runs from the
    // farthest candidate down to the pointer itself so the candidate closest
    // to the pointer is written last and wins. Index is 0 when nothing is
    // valid, which makes the idle write-port pins follow requester 0.
    function automatic logic [IW:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [IW-1:0]      ptr);
        logic [IW:0] result;
        logic [IW:0] cand;
        result = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (vld[cand[IW-1:0]]) begin
                result = {1'b1, cand[IW-1:0]};
            end
        end
        return result;
    endfunction

    logic [IW-1:0] rd_ptr_q, rd_ptr_d;
    logic [IW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IW-1:0] rsp_id_q, rsp_id_d;
    logic          rsp_pending_q, rsp_pending_d;

    logic [IW:0]   rd_pick, wr_pick;
    logic [IW-1:0] rd_idx, wr_idx;
    logic          rd_gnt, wr_gnt;

    always_comb begin
        rd_pick = rr_pick(rd_valid, rd_ptr_q);
        wr_pick = rr_pick(wr_valid, wr_ptr_q);
        rd_idx  = rd_pick[IW-1:0];
        wr_idx  = wr_pick[IW-1:0];
        // Reset masks every grant so nothing reaches the macro while RST is high.
        rd_gnt  = rd_pick[IW] & ~RST;
        wr_gnt  = wr_pick[IW] & ~RST;

        rd_ready = rd_gnt ? (NUM_REQ'(1) << rd_idx) : '0;
        wr_ready = wr_gnt ? (NUM_REQ'(1) << wr_idx) : '0;

        REB = rd_gnt;
        AB  = rd_addr_arr[rd_idx];
        WEB = wr_gnt;
        AA  = wr_addr_arr[wr_idx];
        D   = wr_data_arr[wr_idx];
        M   = wr_mask_arr[wr_idx];

        // Q is already registered inside the macro, so the response is a
        // straight passthrough qualified by the tag captured last cycle.
        rsp_valid = (rsp_pending_q & ~RST) ? (NUM_REQ'(1) << rsp_id_q) : '0;
        rsp_data  = Q;

        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        rsp_id_d      = rsp_id_q;
        rsp_pending_d = rd_gnt;
        if (rd_gnt) begin
            rd_ptr_d = (rd_idx == LAST) ? '0 : rd_idx + 1'b1;
            rsp_id_d = rd_idx;
        end
        if (wr_gnt) begin
            wr_ptr_d = (wr_idx == LAST) ? '0 : wr_idx + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rsp_id_q      <= '0;
            rsp_pending_q <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rsp_id_q      <= rsp_id_d;
            rsp_pending_q <= rsp_pending_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Drives a 2-requester arbiter attached to a behavioural masked SRAM and a
// 3-requester arbiter (read port only) through directed scenarios and a
// randomized run checked against a round-robin / memory reference model.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int W2 = 64;
    localparam int A2 = 4;
    localparam int W3 = 8;
    localparam int A3 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- 2-requester instance ----------------
    logic              rst2;
    logic [1:0]        rd_valid2, rd_ready2, rsp_valid2, wr_valid2, wr_ready2;
    logic [2*A2-1:0]   rd_addr2, wr_addr2;
    logic [2*W2-1:0]   wr_data2, wr_mask2;
    logic [W2-1:0]     rsp_data2, D2, M2, Q2;
    logic              REB2, WEB2;
    logic [A2-1:0]     AB2, AA2;

    sram_port_arbiter #(.WIDTH(W2), .NUM_ROWS(16), .NUM_REQ(2)) u2 (
        .CLK(clk), .RST(rst2),
        .rd_valid(rd_valid2), .rd_ready(rd_ready2), .rd_addr(rd_addr2),
        .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
        .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_addr(wr_addr2),
        .wr_data(wr_data2), .wr_mask(wr_mask2),
        .REB(REB2), .AB(AB2), .WEB(WEB2), .AA(AA2), .D(D2), .M(M2), .Q(Q2)
    );

    // Behavioural macro: registered read, masked write, read-before-write.
    logic [W2-1:0] mem2 [16];
    always @(posedge clk) begin
        if (REB2) Q2 <= mem2[AB2];
        if (WEB2) mem2[AA2] <= (D2 & M2) | (mem2[AA2] & ~M2);
    end

    // ---------------- 3-requester instance ----------------
    logic              rst3;
    logic [2:0]        rd_valid3, rd_ready3, rsp_valid3, wr_valid3, wr_ready3;
    logic [3*A3-1:0]   rd_addr3, wr_addr3;
    logic [3*W3-1:0]   wr_data3, wr_mask3;
    logic [W3-1:0]     rsp_data3, D3, M3, Q3;
    logic              REB3, WEB3;
    logic [A3-1:0]     AB3, AA3;

    sram_port_arbiter #(.WIDTH(W3), .NUM_ROWS(16), .NUM_REQ(3)) u3 (
        .CLK(clk), .RST(rst3),
        .rd_valid(rd_valid3), .rd_ready(rd_ready3), .rd_addr(rd_addr3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
        .wr_valid(wr_valid3), .wr_ready(wr_ready3), .wr_addr(wr_addr3),
        .wr_data(wr_data3), .wr_mask(wr_mask3),
        .REB(REB3), .AB(AB3), .WEB(WEB3), .AA(AA3), .D(D3), .M(M3), .Q(Q3)
    );

    // ---------------- reference model (2-requester) ----------------
    int            m_rd_ptr = 0;
    int            m_wr_ptr = 0;
    bit            m_pend   = 1'b0;
    int            m_id     = 0;
    logic [W2-1:0] m_data;
    logic [W2-1:0] ref_mem [16];

    // First valid requester at or after ptr, modulo n; -1 if none.
    function automatic int rr_pick(input int ptr, input logic [7:0] vld, input int n);
        int idx;
        for (int k = 0; k < n; k++) begin
            idx = (ptr + k) % n;
            if (vld[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [1:0] oh2(input int g);
        return (g < 0) ? 2'b00 : 2'(1 << g);
    endfunction

    // Apply one cycle's effects to the model (called after the cycle's checks).
    task automatic track2();
        int gr, gw, a;
        gr = rr_pick(m_rd_ptr, {6'b0, rd_valid2}, 2);
        gw = rr_pick(m_wr_ptr, {6'b0, wr_valid2}, 2);
        if (rst2) begin
            m_rd_ptr = 0; m_wr_ptr = 0; m_pend = 1'b0;
            return;
        end
        if (gr >= 0) begin
            m_pend   = 1'b1;
            m_id     = gr;
            m_data   = ref_mem[rd_addr2[gr*A2 +: A2]];
            m_rd_ptr = (gr + 1) % 2;
        end else begin
            m_pend = 1'b0;
        end
        if (gw >= 0) begin
            a = int'(wr_addr2[gw*A2 +: A2]);
            ref_mem[a] = (wr_data2[gw*W2 +: W2] & wr_mask2[gw*W2 +: W2]) |
                         (ref_mem[a] & ~wr_mask2[gw*W2 +: W2]);
            m_wr_ptr = (gw + 1) % 2;
        end
    endtask

    // Wait one edge, drive the 2-requester inputs, let combinational paths settle.
    task automatic drive2(input logic rst, input logic [1:0] rv,
                          input logic [A2-1:0] ra0, input logic [A2-1:0] ra1,
                          input logic [1:0] wv,
                          input logic [A2-1:0] wa0, input logic [A2-1:0] wa1,
                          input logic [W2-1:0] wd0, input logic [W2-1:0] wd1,
                          input logic [W2-1:0] wm0, input logic [W2-1:0] wm1);
        @(posedge clk);
        #1;
        rst2 = rst; rd_valid2 = rv; rd_addr2 = {ra1, ra0};
        wr_valid2 = wv; wr_addr2 = {wa1, wa0};
        wr_data2 = {wd1, wd0}; wr_mask2 = {wm1, wm0};
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive2(1'b1, 2'b11, 4'd5, 4'd9, 2'b11, 4'd1, 4'd2, '1, '1, '1, '1);
            total++;
            if (rd_ready2 !== 2'b00 || wr_ready2 !== 2'b00) begin
                bad++; $display("FAIL reset_ready c=%0d got rd=%b wr=%b want 00/00", c, rd_ready2, wr_ready2);
            end
            total++;
            if (REB2 !== 1'b0 || WEB2 !== 1'b0 || rsp_valid2 !== 2'b00) begin
                bad++; $display("FAIL reset_pins c=%0d got REB=%b WEB=%b rsp=%b want 0/0/00", c, REB2, WEB2, rsp_valid2);
            end
            track2();
        end
    endtask

    task automatic test_fill();
        logic [W2-1:0] d;
        logic [1:0]    wv;
        for (int r = 0; r < 16; r++) begin
            d  = {$urandom(), $urandom()};
            wv = (r % 2 == 1) ? 2'b10 : 2'b01;
            drive2(1'b0, 2'b00, 4'd0, 4'd0, wv, 4'(r), 4'(r), d, d, '1, '1);
            total++;
            if (wr_ready2 !== wv || WEB2 !== 1'b1 || AA2 !== 4'(r) || D2 !== d) begin
                bad++; $display("FAIL fill r=%0d got rdy=%b WEB=%b AA=%0d D=%h want %b/1/%0d/%h", r, wr_ready2, WEB2, AA2, D2, wv, r, d);
            end
            track2();
        end
    endtask

    task automatic test_rr_read();
        logic [1:0]    exp_rdy [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [A2-1:0] exp_ab  [4] = '{4'd5, 4'd9, 4'd5, 4'd9};
        for (int c = 0; c < 5; c++) begin
            drive2(1'b0, (c < 4) ? 2'b11 : 2'b00, 4'd5, 4'd9, 2'b00, 4'd0, 4'd0, '0, '0, '0, '0);
            if (c < 4) begin
                total++;
                if (rd_ready2 !== exp_rdy[c] || AB2 !== exp_ab[c] || REB2 !== 1'b1) begin
                    bad++; $display("FAIL rr_grant c=%0d got rdy=%b AB=%0d REB=%b want %b/%0d/1", c, rd_ready2, AB2, REB2, exp_rdy[c], exp_ab[c]);
                end
            end
            if (c > 0) begin
                total++;
                if (rsp_valid2 !== exp_rdy[c-1] || rsp_data2 !== ref_mem[exp_ab[c-1]]) begin
                    bad++; $display("FAIL rr_rsp c=%0d got v=%b d=%h want %b/%h", c, rsp_valid2, rsp_data2, exp_rdy[c-1], ref_mem[exp_ab[c-1]]);
                end
            end
            track2();
        end
    endtask

    task automatic test_masked_write();
        drive2(1'b0, 2'b00, 4'd0, 4'd0, 2'b10, 4'd0, 4'd3, '0, '1, '0, '1);
        total++;
        if (wr_ready2 !== 2'b10) begin
            bad++; $display("FAIL mw_first got=%b want=10", wr_ready2);
        end
        track2();
        drive2(1'b0, 2'b00, 4'd0, 4'd0, 2'b01, 4'd3, 4'd0, '0, '0, 64'hFF, '0);
        total++;
        if (wr_ready2 !== 2'b01 || M2 !== 64'hFF || D2 !== 64'h0) begin
            bad++; $display("FAIL mw_second got rdy=%b M=%h D=%h want 01/ff/0", wr_ready2, M2, D2);
        end
        track2();
        drive2(1'b0, 2'b01, 4'd3, 4'd0, 2'b00, 4'd0, 4'd0, '0, '0, '0, '0);
        track2();
        drive2(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, '0, '0, '0, '0);
        total++;
        if (rsp_valid2 !== 2'b01 || rsp_data2 !== 64'hFFFF_FFFF_FFFF_FF00) begin
            bad++; $display("FAIL mw_read got v=%b d=%h want 01/ffffffffffffff00", rsp_valid2, rsp_data2);
        end
        track2();
    endtask

    task automatic test_rbw();
        drive2(1'b0, 2'b00, 4'd0, 4'd0, 2'b01, 4'd7, 4'd0, 64'hA, '0, '1, '0);
        track2();
        drive2(1'b0, 2'b01, 4'd7, 4'd0, 2'b10, 4'd0, 4'd7, '0, 64'hB, '0, '1);
        total++;
        if (rd_ready2 !== 2'b01 || wr_ready2 !== 2'b10) begin
            bad++; $display("FAIL rbw_grant got rd=%b wr=%b want 01/10", rd_ready2, wr_ready2);
        end
        track2();
        drive2(1'b0, 2'b01, 4'd7, 4'd0, 2'b00, 4'd0, 4'd0, '0, '0, '0, '0);
        total++;
        if (rsp_valid2 !== 2'b01 || rsp_data2 !== 64'hA) begin
            bad++; $display("FAIL rbw_old got v=%b d=%h want 01/a", rsp_valid2, rsp_data2);
        end
        track2();
        drive2(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, '0, '0, '0, '0);
        total++;
        if (rsp_valid2 !== 2'b01 || rsp_data2 !== 64'hB) begin
            bad++; $display("FAIL rbw_new got v=%b d=%h want 01/b", rsp_valid2, rsp_data2);
        end
        track2();
    endtask

    task automatic test_wr_priority();
        logic [1:0] exp_w [5] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        for (int c = 0; c < 5; c++) begin
            drive2(1'b0, 2'b00, 4'd0, 4'd0, (c < 3) ? 2'b10 : 2'b11, 4'(c), 4'(c + 8),
                   {$urandom(), $urandom()}, {$urandom(), $urandom()}, '1, '1);
            total++;
            if (wr_ready2 !== exp_w[c]) begin
                bad++; $display("FAIL wr_prio c=%0d got=%b want=%b", c, wr_ready2, exp_w[c]);
            end
            track2();
        end
    endtask

    task automatic test_reset_inflight();
        drive2(1'b0, 2'b01, 4'd5, 4'd0, 2'b00, 4'd0, 4'd0, '0, '0, '0, '0);
        total++;
        if (rd_ready2 !== 2'b01) begin
            bad++; $display("FAIL rsti_grant got=%b want=01", rd_ready2);
        end
        track2();
        for (int c = 0; c < 2; c++) begin
            drive2(1'b1, 2'b11, 4'd5, 4'd9, 2'b11, 4'd1, 4'd2, '1, '1, '1, '1);
            total++;
            if (rsp_valid2 !== 2'b00) begin
                bad++; $display("FAIL rsti_rsp c=%0d got=%b want=00", c, rsp_valid2);
            end
            total++;
            if (REB2 !== 1'b0 || WEB2 !== 1'b0 || rd_ready2 !== 2'b00 || wr_ready2 !== 2'b00) begin
                bad++; $display("FAIL rsti_force c=%0d got REB=%b WEB=%b rd=%b wr=%b want all 0", c, REB2, WEB2, rd_ready2, wr_ready2);
            end
            track2();
        end
        drive2(1'b0, 2'b11, 4'd5, 4'd9, 2'b00, 4'd0, 4'd0, '0, '0, '0, '0);
        total++;
        if (rd_ready2 !== 2'b01 || rsp_valid2 !== 2'b00) begin
            bad++; $display("FAIL rsti_release got rdy=%b rsp=%b want 01/00", rd_ready2, rsp_valid2);
        end
        track2();
        drive2(1'b0, 2'b00, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, '0, '0, '0, '0);
        total++;
        if (rsp_valid2 !== 2'b01 || rsp_data2 !== ref_mem[5]) begin
            bad++; $display("FAIL rsti_after got v=%b d=%h want 01/%h", rsp_valid2, rsp_data2, ref_mem[5]);
        end
        track2();
    endtask

    task automatic test_wrap3();
        logic [2:0] exp_g;
        logic [2:0] prev_g;
        @(posedge clk); #1;
        rst3 = 1'b1; rd_valid3 = 3'b111;
        #1;
        total++;
        if (rd_ready3 !== 3'b000 || REB3 !== 1'b0) begin
            bad++; $display("FAIL wrap3_reset got rdy=%b REB=%b want 000/0", rd_ready3, REB3);
        end
        prev_g = 3'b000;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            rst3 = 1'b0; rd_valid3 = (c < 6) ? 3'b111 : 3'b000;
            rd_addr3 = {4'(c), 4'(c + 1), 4'(c + 2)};
            #1;
            exp_g = (c < 6) ? 3'(1 << (c % 3)) : 3'b000;
            total++;
            if (rd_ready3 !== exp_g) begin
                bad++; $display("FAIL wrap3_grant c=%0d got=%b want=%b", c, rd_ready3, exp_g);
            end
            total++;
            if (rsp_valid3 !== prev_g) begin
                bad++; $display("FAIL wrap3_rsp c=%0d got=%b want=%b", c, rsp_valid3, prev_g);
            end
            prev_g = exp_g;
        end
    endtask

    task automatic test_random();
        int gr, gw;
        logic rst;
        logic [1:0] exp_r, exp_w, exp_v;
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive2(rst, 2'($urandom()), 4'($urandom()), 4'($urandom()),
                   2'($urandom()), 4'($urandom()), 4'($urandom()),
                   {$urandom(), $urandom()}, {$urandom(), $urandom()},
                   {$urandom(), $urandom()}, {$urandom(), $urandom()});
            gr = rr_pick(m_rd_ptr, {6'b0, rd_valid2}, 2);
            gw = rr_pick(m_wr_ptr, {6'b0, wr_valid2}, 2);
            exp_r = rst ? 2'b00 : oh2(gr);
            exp_w = rst ? 2'b00 : oh2(gw);
            exp_v = (m_pend && !rst) ? oh2(m_id) : 2'b00;
            total++;
            if (rd_ready2 !== exp_r || REB2 !== (exp_r != 2'b00)) begin
                bad++; $display("FAIL rnd_rd c=%0d got rdy=%b REB=%b want %b", c, rd_ready2, REB2, exp_r);
            end
            if (exp_r != 2'b00) begin
                total++;
                if (AB2 !== rd_addr2[gr*A2 +: A2]) begin
                    bad++; $display("FAIL rnd_ab c=%0d got=%0d want=%0d", c, AB2, rd_addr2[gr*A2 +: A2]);
                end
            end
            total++;
            if (wr_ready2 !== exp_w || WEB2 !== (exp_w != 2'b00)) begin
                bad++; $display("FAIL rnd_wr c=%0d got rdy=%b WEB=%b want %b", c, wr_ready2, WEB2, exp_w);
            end
            if (exp_w != 2'b00) begin
                total++;
                if (AA2 !== wr_addr2[gw*A2 +: A2] || D2 !== wr_data2[gw*W2 +: W2] || M2 !== wr_mask2[gw*W2 +: W2]) begin
                    bad++; $display("FAIL rnd_wpins c=%0d got AA=%0d D=%h M=%h want req %0d", c, AA2, D2, M2, gw);
                end
            end
            total++;
            if (rsp_valid2 !== exp_v) begin
                bad++; $display("FAIL rnd_rspv c=%0d got=%b want=%b", c, rsp_valid2, exp_v);
            end
            if (exp_v != 2'b00) begin
                total++;
                if (rsp_data2 !== m_data) begin
                    bad++; $display("FAIL rnd_rspd c=%0d got=%h want=%h", c, rsp_data2, m_data);
                end
            end
            track2();
        end
    endtask

    initial begin
        rst2 = 1'b1; rd_valid2 = '0; rd_addr2 = '0; wr_valid2 = '0;
        wr_addr2 = '0; wr_data2 = '0; wr_mask2 = '0;
        rst3 = 1'b1; rd_valid3 = '0; rd_addr3 = '0; wr_valid3 = '0;
        wr_addr3 = '0; wr_data3 = '0; wr_mask3 = '0; Q3 = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        test_reset();
        test_fill();
        test_rr_read();
        test_masked_write();
        test_rbw();
        test_wr_priority();
        test_reset_inflight();
        test_wrap3();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
